// File: rtl/cache_prof_pkg.sv
// Shared types and default-geometry constants for the trace-driven cache profiler.
// The top re-derives its field widths from its own parameters with width_of().
package cache_prof_pkg;

   localparam int ADDR_W_DEF     = 32;
   localparam int SETS_DEF       = 16;
   localparam int WAYS_DEF       = 4;
   localparam int LINE_BYTES_DEF = 16;

   localparam int OFF_W = $clog2(LINE_BYTES_DEF);
   localparam int IDX_W = $clog2(SETS_DEF);
   localparam int TAG_W = ADDR_W_DEF - OFF_W - IDX_W;
   localparam int AGE_W = (WAYS_DEF > 1) ? $clog2(WAYS_DEF) : 1;

   // Stored tags are zero-extended into this field, so ADDR_W must not exceed it.
   localparam int TAG_MAX_W = 32;

   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic [1:0] {
      IDLE,
      FLUSH,
      LOOKUP,
      UPDATE
   } fsm_state_t;

   typedef struct packed {
      logic                 valid;
      logic [TAG_MAX_W-1:0] tag;
   } line_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating statistics counter; clear dominates a same-cycle increment.
module sat_counter #(
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q, count_d;

   // NOTE: assign a default first in always_comb so no path leaves count_d unassigned (no latch).
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != '1)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/cache_trace_profiler.sv
// Set-associative cache model with true-LRU ages; classifies one trace address
// every three cycles and keeps saturating access/hit/miss/eviction counts.
module cache_trace_profiler
   import cache_prof_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int SETS       = 16,
   parameter int WAYS       = 4,
   parameter int LINE_BYTES = 16,
   parameter int CNT_W      = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              trace_valid,
   output logic              trace_ready,
   input  logic [ADDR_W-1:0] trace_addr,
   input  logic              flush,
   input  logic              clear_stats,
   output logic              updated,
   output logic              last_hit,
   output logic [CNT_W-1:0]  access_count,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count,
   output logic [CNT_W-1:0]  evict_count
);

   localparam int OFF_B = $clog2(LINE_BYTES);
   localparam int IDX_B = $clog2(SETS);
   localparam int TAG_B = ADDR_W - OFF_B - IDX_B;
   localparam int AGE_B = width_of(WAYS);
   localparam int WAY_B = width_of(WAYS);

   fsm_state_t       state_q, state_d;
   line_t            lines_q [SETS][WAYS];
   line_t            lines_d [SETS][WAYS];
   logic [AGE_B-1:0] ages_q  [SETS][WAYS];
   logic [AGE_B-1:0] ages_d  [SETS][WAYS];
   logic [IDX_B-1:0] idx_q, idx_d;
   logic [TAG_B-1:0] tag_q, tag_d;
   logic [WAY_B-1:0] way_q, way_d;
   logic             hit_q, hit_d;
   logic             evict_q, evict_d;

   logic             hit_any, free_any;
   logic [WAY_B-1:0] hit_way, free_way, lru_way;
   logic [AGE_B-1:0] tgt_age;

   if (OFF_B > 0) begin : g_offset
      logic unused_offset;
      assign unused_offset = ^trace_addr[OFF_B-1:0];
   end

   // Descending scan so the lowest-index invalid way is the one left in free_way.
   always_comb begin
      hit_any  = 1'b0;
      hit_way  = '0;
      free_any = 1'b0;
      free_way = '0;
      lru_way  = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!lines_q[idx_q][w].valid) begin
            free_any = 1'b1;
            free_way = WAY_B'(w);
         end
         if (ages_q[idx_q][w] == AGE_B'(WAYS - 1)) begin
            lru_way = WAY_B'(w);
         end
         if (lines_q[idx_q][w].valid && (lines_q[idx_q][w].tag == TAG_MAX_W'(tag_q))) begin
            hit_any = 1'b1;
            hit_way = WAY_B'(w);
         end
      end
   end

   assign tgt_age = ages_q[idx_q][way_q];

   always_comb begin
      state_d     = state_q;
      lines_d     = lines_q;
      ages_d      = ages_q;
      idx_d       = idx_q;
      tag_d       = tag_q;
      way_d       = way_q;
      hit_d       = hit_q;
      evict_d     = evict_q;
      trace_ready = 1'b0;
      updated     = 1'b0;
      case (state_q)
         IDLE: begin
            trace_ready = !reset && !flush;
            if (flush) begin
               state_d = FLUSH;
            end else if (trace_valid) begin
               idx_d   = trace_addr[OFF_B+IDX_B-1:OFF_B];
               tag_d   = trace_addr[ADDR_W-1:OFF_B+IDX_B];
               state_d = LOOKUP;
            end
         end
         FLUSH: begin
            for (int s = 0; s < SETS; s++) begin
               for (int w = 0; w < WAYS; w++) begin
                  lines_d[s][w] = '0;
                  ages_d[s][w]  = AGE_B'(w);
               end
            end
            state_d = IDLE;
         end
         LOOKUP: begin
            hit_d   = hit_any;
            evict_d = !hit_any && !free_any;
            if (hit_any) begin
               way_d = hit_way;
            end else if (free_any) begin
               way_d = free_way;
            end else begin
               way_d = lru_way;
            end
            state_d = UPDATE;
         end
         UPDATE: begin
            updated = 1'b1;
            lines_d[idx_q][way_q] = '{valid: 1'b1, tag: TAG_MAX_W'(tag_q)};
            // Ages younger than the target's shift back by one, keeping a permutation.
            for (int w = 0; w < WAYS; w++) begin
               if (ages_q[idx_q][w] < tgt_age) begin
                  ages_d[idx_q][w] = ages_q[idx_q][w] + AGE_B'(1);
               end
            end
            ages_d[idx_q][way_q] = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: tag/age arrays are flops, not RAM, so reset can initialise every entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               lines_q[s][w] <= '0;
               ages_q[s][w]  <= AGE_B'(w);
            end
         end
         idx_q   <= '0;
         tag_q   <= '0;
         way_q   <= '0;
         hit_q   <= 1'b0;
         evict_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lines_q <= lines_d;
         ages_q  <= ages_d;
         idx_q   <= idx_d;
         tag_q   <= tag_d;
         way_q   <= way_d;
         hit_q   <= hit_d;
         evict_q <= evict_d;
      end
   end

   assign last_hit = hit_q;

   sat_counter #(.CNT_W(CNT_W)) u_access_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc_i  (updated),
      .clr_i  (clear_stats),
      .count_o(access_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc_i  (updated && hit_q),
      .clr_i  (clear_stats),
      .count_o(hit_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc_i  (updated && !hit_q),
      .clr_i  (clear_stats),
      .count_o(miss_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_evict_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc_i  (updated && evict_q),
      .clr_i  (clear_stats),
      .count_o(evict_count)
   );

endmodule

// File: tb/tb_cache_trace_profiler.sv
// Directed bench: two profilers (4 sets x 2 ways, 16-byte lines) sharing stimulus,
// one with 10-bit counters and one with 4-bit counters for saturation.
module tb_cache_trace_profiler;

   logic        clk;
   logic        reset;
   logic        trace_valid;
   logic [31:0] trace_addr;
   logic        flush;
   logic        clear_stats;

   logic       a_ready, a_updated, a_last_hit;
   logic [9:0] a_access, a_hit, a_miss, a_evict;
   logic       b_ready, b_updated, b_last_hit;
   logic [3:0] b_access, b_hit, b_miss, b_evict;

   int checks   = 0;
   int failures = 0;

   cache_trace_profiler #(
      .ADDR_W(32), .SETS(4), .WAYS(2), .LINE_BYTES(16), .CNT_W(10)
   ) dut_a (
      .clk         (clk),
      .reset       (reset),
      .trace_valid (trace_valid),
      .trace_ready (a_ready),
      .trace_addr  (trace_addr),
      .flush       (flush),
      .clear_stats (clear_stats),
      .updated     (a_updated),
      .last_hit    (a_last_hit),
      .access_count(a_access),
      .hit_count   (a_hit),
      .miss_count  (a_miss),
      .evict_count (a_evict)
   );

   cache_trace_profiler #(
      .ADDR_W(32), .SETS(4), .WAYS(2), .LINE_BYTES(16), .CNT_W(4)
   ) dut_b (
      .clk         (clk),
      .reset       (reset),
      .trace_valid (trace_valid),
      .trace_ready (b_ready),
      .trace_addr  (trace_addr),
      .flush       (flush),
      .clear_stats (clear_stats),
      .updated     (b_updated),
      .last_hit    (b_last_hit),
      .access_count(b_access),
      .hit_count   (b_hit),
      .miss_count  (b_miss),
      .evict_count (b_evict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic do_reset();
      reset       = 1'b1;
      trace_valid = 1'b0;
      trace_addr  = '0;
      flush       = 1'b0;
      clear_stats = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Issue one access and return once counters reflect it; hit is last_hit during updated.
   task automatic access(input logic [31:0] addr, output logic hit);
      int n;
      trace_addr  = addr;
      trace_valid = 1'b1;
      n = 0;
      while (!a_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      @(posedge clk);
      #1;
      trace_valid = 1'b0;
      n = 0;
      while (!a_updated && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (a_updated !== 1'b1) begin
         failures++;
         $display("FAIL access_timeout addr=%h: updated=%b required 1", addr, a_updated);
      end
      hit = a_last_hit;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      trace_valid = 1'b1;
      trace_addr  = 32'h0;
      flush       = 1'b0;
      clear_stats = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (a_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready_low: got %b required 0", a_ready);
      end
      trace_valid = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (a_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready_idle: got %b required 1", a_ready);
      end
      checks++;
      if ({a_updated, a_last_hit} !== 2'b00) begin
         failures++;
         $display("FAIL reset_flags: updated/last_hit got %b required 00", {a_updated, a_last_hit});
      end
      checks++;
      if ({a_access, a_hit, a_miss, a_evict} !== 40'h0) begin
         failures++;
         $display("FAIL reset_counters: got %0d/%0d/%0d/%0d required 0/0/0/0",
                  a_access, a_hit, a_miss, a_evict);
      end
   endtask

   task automatic test_lru();
      logic [31:0] addrs [5];
      logic        exp_hit [5];
      logic        h;
      addrs   = '{32'h000, 32'h004, 32'h040, 32'h080, 32'h000};
      exp_hit = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         access(addrs[i], h);
         checks++;
         if (h !== exp_hit[i]) begin
            failures++;
            $display("FAIL lru_last_hit[%0d] addr=%h: got %b required %b", i, addrs[i], h, exp_hit[i]);
         end
      end
      checks++;
      if (a_access !== 10'd5 || a_hit !== 10'd1) begin
         failures++;
         $display("FAIL lru_access_hit: got %0d/%0d required 5/1", a_access, a_hit);
      end
      checks++;
      if (a_miss !== 10'd4 || a_evict !== 10'd2) begin
         failures++;
         $display("FAIL lru_miss_evict: got %0d/%0d required 4/2", a_miss, a_evict);
      end
   endtask

   task automatic test_back_to_back();
      int   acc_cyc [6];
      int   upd_cyc [6];
      int   n_acc;
      int   n_upd;
      logic lookup_next;
      logic accepted;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         acc_cyc[k] = -100;
         upd_cyc[k] = -100;
      end
      n_acc       = 0;
      n_upd       = 0;
      lookup_next = 1'b0;
      trace_addr  = 32'h1000;
      trace_valid = 1'b1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         accepted = 1'b0;
         if (lookup_next) begin
            checks++;
            if (a_ready !== 1'b0) begin
               failures++;
               $display("FAIL b2b_ready_lookup cycle %0d: got %b required 0", cyc, a_ready);
            end
         end
         lookup_next = 1'b0;
         if (a_updated === 1'b1) begin
            checks++;
            if (a_ready !== 1'b0) begin
               failures++;
               $display("FAIL b2b_ready_update cycle %0d: got %b required 0", cyc, a_ready);
            end
            if (n_upd < 6) upd_cyc[n_upd] = cyc;
            n_upd++;
         end
         if (trace_valid && a_ready === 1'b1) begin
            if (n_acc < 6) acc_cyc[n_acc] = cyc;
            n_acc++;
            lookup_next = 1'b1;
            accepted    = 1'b1;
         end
         @(posedge clk);
         #1;
         if (accepted) begin
            if (n_acc >= 6) trace_valid = 1'b0;
            else trace_addr = 32'h1000 + 32'h40 * n_acc;
         end
      end
      trace_valid = 1'b0;
      checks++;
      if (n_acc != 6 || n_upd != 6) begin
         failures++;
         $display("FAIL b2b_counts: acceptances=%0d updates=%0d required 6/6", n_acc, n_upd);
      end
      for (int k = 0; k < 6; k++) begin
         if (k > 0) begin
            checks++;
            if (acc_cyc[k] - acc_cyc[k-1] != 3) begin
               failures++;
               $display("FAIL b2b_spacing[%0d]: got %0d required 3", k, acc_cyc[k] - acc_cyc[k-1]);
            end
         end
         checks++;
         if (upd_cyc[k] != acc_cyc[k] + 2) begin
            failures++;
            $display("FAIL b2b_latency[%0d]: updated at %0d required %0d", k, upd_cyc[k], acc_cyc[k] + 2);
         end
      end
      checks++;
      if (a_access !== 10'd6) begin
         failures++;
         $display("FAIL b2b_access_count: got %0d required 6", a_access);
      end
   endtask

   task automatic test_saturation();
      logic h;
      do_reset();
      for (int i = 0; i < 21; i++) access(32'h000, h);
      checks++;
      if (b_hit !== 4'd15 || b_miss !== 4'd1 || b_access !== 4'd15) begin
         failures++;
         $display("FAIL sat_narrow: hit/miss/access got %0d/%0d/%0d required 15/1/15",
                  b_hit, b_miss, b_access);
      end
      checks++;
      if (b_evict !== 4'd0) begin
         failures++;
         $display("FAIL sat_narrow_evict: got %0d required 0", b_evict);
      end
      checks++;
      if (a_hit !== 10'd20 || a_miss !== 10'd1 || a_access !== 10'd21) begin
         failures++;
         $display("FAIL sat_wide: hit/miss/access got %0d/%0d/%0d required 20/1/21",
                  a_hit, a_miss, a_access);
      end
   endtask

   task automatic test_clear_stats();
      logic h;
      int   n;
      do_reset();
      access(32'h000, h);
      trace_addr  = 32'h000;
      trace_valid = 1'b1;
      @(posedge clk);
      #1;
      trace_valid = 1'b0;
      n = 0;
      while (!a_updated && n < 5) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (a_updated !== 1'b1) begin
         failures++;
         $display("FAIL clear_wait_update: got %b required 1", a_updated);
      end
      clear_stats = 1'b1;
      @(posedge clk);
      #1;
      clear_stats = 1'b0;
      checks++;
      if ({a_access, a_hit, a_miss, a_evict} !== 40'h0) begin
         failures++;
         $display("FAIL clear_counters: got %0d/%0d/%0d/%0d required 0/0/0/0",
                  a_access, a_hit, a_miss, a_evict);
      end
      access(32'h000, h);
      checks++;
      if (h !== 1'b1) begin
         failures++;
         $display("FAIL clear_keeps_line: last_hit got %b required 1", h);
      end
      checks++;
      if (a_hit !== 10'd1 || a_miss !== 10'd0 || a_access !== 10'd1) begin
         failures++;
         $display("FAIL clear_after: hit/miss/access got %0d/%0d/%0d required 1/0/1",
                  a_hit, a_miss, a_access);
      end
   endtask

   task automatic test_flush();
      logic h;
      do_reset();
      access(32'h040, h);
      access(32'h080, h);
      access(32'h000, h);
      access(32'h000, h);
      checks++;
      if (h !== 1'b1 || a_evict !== 10'd1) begin
         failures++;
         $display("FAIL flush_warm: last_hit/evict got %b/%0d required 1/1", h, a_evict);
      end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checks++;
      if (a_ready !== 1'b0) begin
         failures++;
         $display("FAIL flush_ready_low: got %b required 0", a_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (a_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_ready_back: got %b required 1", a_ready);
      end
      access(32'h000, h);
      checks++;
      if (h !== 1'b0 || a_evict !== 10'd1 || a_miss !== 10'd4) begin
         failures++;
         $display("FAIL flush_reaccess: last_hit/evict/miss got %b/%0d/%0d required 0/1/4",
                  h, a_evict, a_miss);
      end
   endtask

   task automatic test_reset_mid();
      logic h;
      do_reset();
      trace_addr  = 32'h100;
      trace_valid = 1'b1;
      @(posedge clk);
      #1;
      trace_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (a_updated !== 1'b0 || a_ready !== 1'b0) begin
         failures++;
         $display("FAIL midreset_in_reset: updated/ready got %b/%b required 0/0", a_updated, a_ready);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (a_ready !== 1'b1 || a_updated !== 1'b0) begin
         failures++;
         $display("FAIL midreset_after: ready/updated got %b/%b required 1/0", a_ready, a_updated);
      end
      checks++;
      if ({a_access, a_hit, a_miss, a_evict} !== 40'h0) begin
         failures++;
         $display("FAIL midreset_counters: got %0d/%0d/%0d/%0d required 0/0/0/0",
                  a_access, a_hit, a_miss, a_evict);
      end
      access(32'h100, h);
      checks++;
      if (h !== 1'b0 || a_miss !== 10'd1 || a_evict !== 10'd0 || a_access !== 10'd1) begin
         failures++;
         $display("FAIL midreset_reaccess: hit/miss/evict/access got %b/%0d/%0d/%0d required 0/1/0/1",
                  h, a_miss, a_evict, a_access);
      end
   endtask

   initial begin
      test_reset();
      test_lru();
      test_back_to_back();
      test_saturation();
      test_clear_stats();
      test_flush();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
